reu_dma_sequencer: RTL and testbench
====================================

// Module: reu_dma_sequencer
// PURPOSE
//  Transfer engine for the REU. It is the initiator side of the register file's control interface.
//  - Consumes: Execute, XferType, Length1.
//  - Returns: IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr.
//  Owns the C64 DMA line, the C64 bus direction and the REU RAM strobes.
//  Moves bytes: stash, fetch, swap and verify.
// PARAMETERS
//  DMA_SETUP  1  PHI2 cycles of DMA asserted before the first transfer cycle (bus turnaround), range 1..7
// PORTS
//  PHI2          in   1  system clock; all state updates on the negedge
//  Reset         in   1  reset, synchronous, active-high
//  Execute       in   1  start pulse from the register file
//  XferType      in   2  00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify
//  Length1       in   1  current length == 1, meaning the byte in flight is the last
//  BA            in   1  VIC bus-available, low = stall (used only with REU_BA_STALL_EN)
//  C64DIn        in   8  data read from the C64 bus
//  RAMDIn        in   8  data read from REU RAM
//  DMAn          out  1  C64 DMA request, active-low
//  C64AOE        out  1  drive CA onto the C64 address bus
//  C64RnW        out  1  C64 R/W: 1 = read, 0 = write
//  C64DOut       out  8  data driven to the C64 bus when C64RnW=0
//  RAMOE         out  1  REU RAM read strobe
//  RAMWE         out  1  REU RAM write strobe
//  RAMDOut       out  8  data written to REU RAM
//  IncCA         out  1  byte-complete strobe to the CA counter
//  IncREUA       out  1  byte-complete strobe to the REUA counter
//  DecLen        out  1  length decrement strobe
//  XferEnd       out  1  one-cycle end-of-transfer strobe (triggers autoload)
//  SetEndOfBlock out  1  one-cycle: the last byte completed
//  SetVerifyErr  out  1  one-cycle: verify mismatch
//  Busy          out  1  state != IDLE
// BEHAVIOUR
//  States: IDLE, SETUP, XA, XB, DONE. State, setup counter, latches S/R and the type register are registered.
//  Strobes are combinational decodes of the current state and inputs. Each strobe is valid for the whole
//  cycle and is consumed by the register file at the negedge that ends it.
//  Reset: state=IDLE, DMAn=1, S=R=0. Every strobe and enable is held 0 while Reset=1.
//  IDLE: Execute=1 latches XferType -> SETUP and loads counter=DMA_SETUP-1. DMAn=0 from SETUP until DONE, inclusive.
//  SETUP: counts down; at 0 -> XA. No bus or RAM activity.
//  XA by type:
//   - stash: C64AOE=1, RnW=1, RAMWE=1, RAMDOut=C64DIn. 1 cycle/byte.
//   - fetch: RAMOE=1, C64AOE=1, RnW=0, C64DOut=RAMDIn. 1 cycle/byte.
//   - verify: C64AOE=1, RnW=1, RAMOE=1, compare C64DIn vs RAMDIn. 1 cycle/byte.
//   - swap: C64AOE=1, RnW=1, RAMOE=1; latch S<=C64DIn, R<=RAMDIn -> XB, no strobes.
//  XB (swap only): C64AOE=1, RnW=0, C64DOut=R, RAMWE=1, RAMDOut=S. Byte completes -> XA or DONE.
//  Byte-complete cycle (XA for types 00/01/11, XB for 10):
//   - IncCA=IncREUA=1.
//   - DecLen=!Length1. Length stays at 1 after the last byte.
//   - Length1=1 -> SetEndOfBlock=1, next state DONE.
//   - Verify mismatch -> SetVerifyErr=1, next state DONE. A mismatch on the last byte sets both flags.
//  DONE: XferEnd=1 for 1 cycle, DMAn=1 next cycle, -> IDLE.
//   Throughput: 1 byte/cycle (stash/fetch/verify), 2 cycles/byte (swap).
//  Length encoding: 0 = 65536. The engine only tests Length1.
//  Boundaries:
//   - Execute while Busy: ignored.
//   - Execute and Reset together: Reset wins.
//   - Reset mid-transfer: IDLE at that edge; no XferEnd; counters keep their partial values.
//   - Length1 already 1 at start: exactly 1 byte moves.
// CONFIGURATION
//  REU_BA_STALL_EN defined:
//   - BA=0 in XA/XB freezes state and latches and forces every strobe and enable to 0.
//   - A swap stalled between XA and XB resumes in XB with the latched data.
//   - BA=0 in SETUP holds the counter.
//  REU_BA_STALL_EN undefined: BA is ignored and the transfer never pauses.
// TESTING
//  1. Stash, Length1=1 at start. Execute -> DMAn low 1+DMA_SETUP+1 cycles; one RAMWE, data 0x5A copied;
//     IncCA=IncREUA=1, DecLen=0, SetEndOfBlock and then XferEnd.
//  2. Fetch of 4 bytes (Length1 rises on the 4th). 4 consecutive C64 write cycles; DecLen pulses 3x; XferEnd once.
//  3. Swap, C64=0x11, RAM=0x22, 1 byte. XA latches; XB drives C64DOut=0x22 and RAMDOut=0x11; exactly one IncCA.
//  4. Verify of 3 bytes with a mismatch on byte 2. SetVerifyErr on byte 2, no SetEndOfBlock, XferEnd next cycle,
//     byte 3 not read.
//  5. Reset asserted in the 2nd XA of a fetch: IDLE, DMAn=1 next edge, no XferEnd. Execute while Busy: no restart.
//  6. With REU_BA_STALL_EN: BA=0 for 3 cycles mid-swap between XA and XB: strobes 0, then XB completes with the
//     correct data.

Source files
------------

// File: rtl/reu_dma_sequencer_if.sv
// reu_dma_sequencer_if: register-file control strobes plus C64 bus and REU RAM signals of the DMA sequencer.
// master = sequencer side, slave = register file / bus side.
interface reu_dma_sequencer_if;
   logic       Execute;
   logic [1:0] XferType;
   logic       Length1;
   logic       BA;
   logic [7:0] C64DIn;
   logic [7:0] RAMDIn;
   logic       DMAn;
   logic       C64AOE;
   logic       C64RnW;
   logic [7:0] C64DOut;
   logic       RAMOE;
   logic       RAMWE;
   logic [7:0] RAMDOut;
   logic       IncCA;
   logic       IncREUA;
   logic       DecLen;
   logic       XferEnd;
   logic       SetEndOfBlock;
   logic       SetVerifyErr;
   logic       Busy;
   modport master (
      input  Execute, XferType, Length1, BA, C64DIn, RAMDIn,
      output DMAn, C64AOE, C64RnW, C64DOut, RAMOE, RAMWE, RAMDOut,
             IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy
   );
   modport slave (
      output Execute, XferType, Length1, BA, C64DIn, RAMDIn,
      input  DMAn, C64AOE, C64RnW, C64DOut, RAMOE, RAMWE, RAMDOut,
             IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy
   );
endinterface

// File: rtl/reu_dma_sequencer.sv
// reu_dma_sequencer: REU transfer engine (stash/fetch/swap/verify), state clocked on the PHI2 negedge.
// Define REU_BA_STALL_EN to let BA=0 pause the transfer.
module reu_dma_sequencer #(
   parameter int DMA_SETUP = 1
) (
   input logic                 PHI2,
   input logic                 Reset,
   reu_dma_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, SETUP, XA, XB, DONE} state_t;
   localparam logic [1:0] STASH = 2'b00, FETCH = 2'b01, SWAP = 2'b10, VERIFY = 2'b11;
   localparam logic [2:0] SETUP_LOAD = 3'(DMA_SETUP - 1);
   state_t state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] type_q, type_d;
   logic [7:0] s_q, s_d, r_q, r_d, c64_dout, ram_dout;
   logic stall, hold, en, aoe, rnw, oe, we, byte_done, verr, xfer_end;
`ifdef REU_BA_STALL_EN
   assign stall = !bus.BA;
`else
   logic unused_ba;
   assign unused_ba = bus.BA;
   assign stall = 1'b0;
`endif
   assign hold = stall && (state_q == SETUP || state_q == XA || state_q == XB);
   always_ff @(negedge PHI2) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         type_q  <= '0;
         s_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
         s_q     <= s_d;
         r_q     <= r_d;
      end
   end
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      type_d    = type_q;
      s_d       = s_q;
      r_d       = r_q;
      aoe       = 1'b0;
      rnw       = 1'b1;
      oe        = 1'b0;
      we        = 1'b0;
      c64_dout  = '0;
      ram_dout  = '0;
      byte_done = 1'b0;
      verr      = 1'b0;
      xfer_end  = 1'b0;
      case (state_q)
         IDLE: if (bus.Execute) begin
            state_d = SETUP;
            cnt_d   = SETUP_LOAD;
            type_d  = bus.XferType;
         end
         SETUP: begin
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q == 3'd0) ? XA : SETUP;
         end
         XA: begin
            aoe       = 1'b1;
            rnw       = type_q != FETCH;
            oe        = type_q != STASH;
            we        = type_q == STASH;
            c64_dout  = bus.RAMDIn;
            ram_dout  = bus.C64DIn;
            verr      = type_q == VERIFY && bus.C64DIn != bus.RAMDIn;
            byte_done = type_q != SWAP;
            if (type_q == SWAP) begin
               s_d     = bus.C64DIn;
               r_d     = bus.RAMDIn;
               state_d = XB;
            end
         end
         XB: begin
            aoe       = 1'b1;
            rnw       = 1'b0;
            we        = 1'b1;
            c64_dout  = r_q;
            ram_dout  = s_q;
            byte_done = 1'b1;
            state_d   = XA;
         end
         DONE: begin
            xfer_end = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (byte_done && (bus.Length1 || verr)) state_d = DONE;
      if (hold) begin
         state_d = state_q;
         cnt_d   = cnt_q;
         s_d     = s_q;
         r_d     = r_q;
      end
   end
   // a stalled bus cycle must not touch either side, so every enable is gated with hold
   assign en                = !Reset && !hold;
   assign bus.DMAn          = Reset || state_q == IDLE;
   assign bus.Busy          = state_q != IDLE;
   assign bus.C64AOE        = en && aoe;
   assign bus.C64RnW        = rnw || !en;
   assign bus.RAMOE         = en && oe;
   assign bus.RAMWE         = en && we;
   assign bus.C64DOut       = c64_dout;
   assign bus.RAMDOut       = ram_dout;
   assign bus.IncCA         = en && byte_done;
   assign bus.IncREUA       = en && byte_done;
   assign bus.DecLen        = en && byte_done && !bus.Length1;
   assign bus.SetEndOfBlock = en && byte_done && bus.Length1;
   assign bus.SetVerifyErr  = en && verr;
   assign bus.XferEnd       = !Reset && xfer_end;
endmodule

// File: tb/tb_reu_dma_sequencer.sv
// tb_reu_dma_sequencer: table-driven per-cycle vectors plus hand sequences for reset and BA stall.
// Control word order: DMAn C64AOE C64RnW RAMOE RAMWE IncCA IncREUA DecLen XferEnd SetEndOfBlock SetVerifyErr Busy.
module tb_reu_dma_sequencer;
   logic PHI2 = 1'b0;
   logic Reset;
   int checks = 0;
   int errors = 0;
   reu_dma_sequencer_if bus();
   reu_dma_sequencer #(.DMA_SETUP(1)) dut (.PHI2(PHI2), .Reset(Reset), .bus(bus));
   always #5 PHI2 = ~PHI2;
   localparam logic [11:0] IDL  = 12'b1010_0000_0000;
   localparam logic [11:0] SET  = 12'b0010_0000_0001;
   localparam logic [11:0] DON  = 12'b0010_0000_1001;
   localparam logic [11:0] STL  = 12'b0110_1110_0101;
   localparam logic [11:0] FMID = 12'b0101_0111_0001;
   localparam logic [11:0] FLST = 12'b0101_0110_0101;
   localparam logic [11:0] SXA  = 12'b0111_0000_0001;
   localparam logic [11:0] SXB  = 12'b0100_1110_0101;
   localparam logic [11:0] VOK  = 12'b0111_0111_0001;
   localparam logic [11:0] VER  = 12'b0111_0111_0011;
   localparam logic [11:0] VLE  = 12'b0111_0110_0111;
   localparam logic [11:0] RST  = 12'b1010_0000_0001;
   typedef struct {
      logic       rst, ex;
      logic [1:0] xt;
      logic       l1;
      logic [7:0] c64, ram;
      logic [11:0] ctrl;
      logic [7:0] ed, er;
   } vec_t;
   vec_t v[32];
   task automatic drive(input logic rst, input logic ex, input logic [1:0] xt, input logic l1,
                        input logic [7:0] c64, input logic [7:0] ram);
      Reset = rst; bus.Execute = ex; bus.XferType = xt; bus.Length1 = l1; bus.C64DIn = c64; bus.RAMDIn = ram;
   endtask
   task automatic chk(input string nm, input logic [11:0] ec, input logic [7:0] ed, input logic [7:0] er);
      logic [11:0] ac;
      logic [7:0] ad, ar;
      @(posedge PHI2);
      ac = {bus.DMAn, bus.C64AOE, bus.C64RnW, bus.RAMOE, bus.RAMWE, bus.IncCA, bus.IncREUA,
            bus.DecLen, bus.XferEnd, bus.SetEndOfBlock, bus.SetVerifyErr, bus.Busy};
      ad = (bus.C64AOE && !bus.C64RnW) ? bus.C64DOut : 8'h00;
      ar = bus.RAMWE ? bus.RAMDOut : 8'h00;
      checks++;
      if ({ac, ad, ar} !== {ec, ed, er}) begin
         errors++;
         $display("FAIL %s: got ctrl=%b c64dout=%h ramdout=%h, want ctrl=%b c64dout=%h ramdout=%h",
                  nm, ac, ad, ar, ec, ed, er);
      end
      @(negedge PHI2);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL timeout: checks=%0d", checks);
      $fatal(1);
   end
   initial begin
      v[0]  = '{1, 1, 2'b00, 0, 8'h00, 8'h00, IDL, 8'h00, 8'h00};
      v[1]  = '{0, 0, 2'b00, 0, 8'h00, 8'h00, IDL, 8'h00, 8'h00};
      v[2]  = '{0, 1, 2'b00, 1, 8'h5A, 8'h00, IDL, 8'h00, 8'h00};
      v[3]  = '{0, 0, 2'b00, 1, 8'h5A, 8'h00, SET, 8'h00, 8'h00};
      v[4]  = '{0, 0, 2'b00, 1, 8'h5A, 8'h00, STL, 8'h00, 8'h5A};
      v[5]  = '{0, 0, 2'b00, 1, 8'h5A, 8'h00, DON, 8'h00, 8'h00};
      v[6]  = '{0, 0, 2'b00, 0, 8'h00, 8'h00, IDL, 8'h00, 8'h00};
      v[7]  = '{0, 1, 2'b01, 0, 8'h00, 8'h10, IDL, 8'h00, 8'h00};
      v[8]  = '{0, 0, 2'b01, 0, 8'h00, 8'h10, SET, 8'h00, 8'h00};
      v[9]  = '{0, 0, 2'b01, 0, 8'h00, 8'h10, FMID, 8'h10, 8'h00};
      v[10] = '{0, 1, 2'b10, 0, 8'h00, 8'h20, FMID, 8'h20, 8'h00};
      v[11] = '{0, 0, 2'b01, 0, 8'h00, 8'h30, FMID, 8'h30, 8'h00};
      v[12] = '{0, 0, 2'b01, 1, 8'h00, 8'h40, FLST, 8'h40, 8'h00};
      v[13] = '{0, 0, 2'b01, 0, 8'h00, 8'h00, DON, 8'h00, 8'h00};
      v[14] = '{0, 0, 2'b01, 0, 8'h00, 8'h00, IDL, 8'h00, 8'h00};
      v[15] = '{0, 1, 2'b10, 1, 8'h11, 8'h22, IDL, 8'h00, 8'h00};
      v[16] = '{0, 0, 2'b10, 1, 8'h11, 8'h22, SET, 8'h00, 8'h00};
      v[17] = '{0, 0, 2'b10, 1, 8'h11, 8'h22, SXA, 8'h00, 8'h00};
      v[18] = '{0, 0, 2'b10, 1, 8'h00, 8'h00, SXB, 8'h22, 8'h11};
      v[19] = '{0, 0, 2'b10, 0, 8'h00, 8'h00, DON, 8'h00, 8'h00};
      v[20] = '{0, 0, 2'b10, 0, 8'h00, 8'h00, IDL, 8'h00, 8'h00};
      v[21] = '{0, 1, 2'b11, 0, 8'h33, 8'h33, IDL, 8'h00, 8'h00};
      v[22] = '{0, 0, 2'b11, 0, 8'h33, 8'h33, SET, 8'h00, 8'h00};
      v[23] = '{0, 0, 2'b11, 0, 8'h33, 8'h33, VOK, 8'h00, 8'h00};
      v[24] = '{0, 0, 2'b11, 0, 8'h44, 8'h45, VER, 8'h00, 8'h00};
      v[25] = '{0, 0, 2'b11, 0, 8'h55, 8'h55, DON, 8'h00, 8'h00};
      v[26] = '{0, 0, 2'b11, 0, 8'h00, 8'h00, IDL, 8'h00, 8'h00};
      v[27] = '{0, 1, 2'b11, 1, 8'h01, 8'h02, IDL, 8'h00, 8'h00};
      v[28] = '{0, 0, 2'b11, 1, 8'h01, 8'h02, SET, 8'h00, 8'h00};
      v[29] = '{0, 0, 2'b11, 1, 8'h01, 8'h02, VLE, 8'h00, 8'h00};
      v[30] = '{0, 0, 2'b11, 0, 8'h00, 8'h00, DON, 8'h00, 8'h00};
      v[31] = '{0, 0, 2'b11, 0, 8'h00, 8'h00, IDL, 8'h00, 8'h00};
      bus.BA = 1'b1;
      drive(1, 0, 2'b00, 0, 8'h00, 8'h00);
      @(negedge PHI2);
      #1;
      for (int i = 0; i < 32; i++) begin
         drive(v[i].rst, v[i].ex, v[i].xt, v[i].l1, v[i].c64, v[i].ram);
         chk($sformatf("vec%0d", i), v[i].ctrl, v[i].ed, v[i].er);
      end
      drive(0, 1, 2'b01, 0, 8'h00, 8'h66); chk("rst_start", IDL, 8'h00, 8'h00);
      drive(0, 0, 2'b01, 0, 8'h00, 8'h66); chk("rst_setup", SET, 8'h00, 8'h00);
      chk("rst_xa1", FMID, 8'h66, 8'h00);
      drive(1, 0, 2'b01, 0, 8'h00, 8'h66); chk("rst_xa2", RST, 8'h00, 8'h00);
      drive(0, 0, 2'b01, 0, 8'h00, 8'h66); chk("rst_after", IDL, 8'h00, 8'h00);
      drive(0, 1, 2'b00, 0, 8'h77, 8'h00); chk("busy_start", IDL, 8'h00, 8'h00);
      drive(0, 1, 2'b01, 0, 8'h77, 8'h00); chk("busy_setup", SET, 8'h00, 8'h00);
      drive(0, 1, 2'b01, 1, 8'h77, 8'h00); chk("busy_xa", STL, 8'h00, 8'h77);
      drive(0, 1, 2'b01, 0, 8'h00, 8'h00); chk("busy_done", DON, 8'h00, 8'h00);
      drive(0, 0, 2'b01, 0, 8'h00, 8'h00); chk("busy_idle", IDL, 8'h00, 8'h00);
`ifdef REU_BA_STALL_EN
      drive(0, 1, 2'b10, 1, 8'hAA, 8'hBB); chk("stall_start", IDL, 8'h00, 8'h00);
      drive(0, 0, 2'b10, 1, 8'hAA, 8'hBB); chk("stall_setup", SET, 8'h00, 8'h00);
      chk("stall_xa", SXA, 8'h00, 8'h00);
      drive(0, 0, 2'b10, 1, 8'h00, 8'h00);
      bus.BA = 1'b0;
      for (int i = 0; i < 3; i++) chk($sformatf("stall_ba%0d", i), SET, 8'h00, 8'h00);
      bus.BA = 1'b1;
      chk("stall_xb", SXB, 8'hBB, 8'hAA);
      chk("stall_done", DON, 8'h00, 8'h00);
      drive(0, 0, 2'b10, 0, 8'h00, 8'h00); chk("stall_idle", IDL, 8'h00, 8'h00);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
